// File: rtl/merge_pkg.sv
// Shared types and helpers for the 2-to-1 merge arbiter.
// MERGE_TAG_EN adds a source-id bit above the payload in each buffered entry.
package merge_pkg;

   typedef enum logic {SRC_L0 = 1'b0, SRC_L1 = 1'b1} src_t;

`ifdef MERGE_TAG_EN
   localparam int TAG_W = 1;
`else
   localparam int TAG_W = 0;
`endif

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/merge_arb_if.sv
// Handshake bundle for the merge: two producer channels (L0, L1) and one consumer (R).
// R_data carries an extra MSB tag bit when MERGE_TAG_EN is defined.
interface merge_arb_if #(
   parameter int WIDTH = 4
);
   localparam int RW = WIDTH + merge_pkg::TAG_W;

   logic [WIDTH-1:0] L0_data;
   logic             L0_valid;
   logic             L0_ready;
   logic [WIDTH-1:0] L1_data;
   logic             L1_valid;
   logic             L1_ready;
   logic [RW-1:0]    R_data;
   logic             R_valid;
   logic             R_ready;

   modport slave (
      input  L0_data, L0_valid, L1_data, L1_valid, R_ready,
      output L0_ready, L1_ready, R_data, R_valid
   );

   modport master (
      output L0_data, L0_valid, L1_data, L1_valid, R_ready,
      input  L0_ready, L1_ready, R_data, R_valid
   );

endinterface

// File: rtl/merge_fifo.sv
// Ring-buffer FIFO behind the merge arbiter; push is refused when full even if popping.
module merge_fifo
   import merge_pkg::*;
#(
   parameter int WIDTH_E = 4,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push_i,
   input  logic [WIDTH_E-1:0] push_data_i,
   input  logic               pop_i,
   output logic [WIDTH_E-1:0] pop_data_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [WIDTH_E-1:0] mem_q [DEPTH];
   logic               do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; contents are meaningless while count is zero.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign pop_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/merge_arb.sv
// Round-robin 2-to-1 merge feeding an output FIFO; ties go to the side not granted last.
// MERGE_TAG_EN stores the winning source id as the MSB of each entry.
module merge_arb
   import merge_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   merge_arb_if.slave  bus
);

   localparam int WIDTH_E = WIDTH + TAG_W;

   src_t               last_grant_q, last_grant_d;
   logic               grant_l0, grant_l1;
   logic               full, empty, push;
   logic [WIDTH-1:0]   win_data;
   logic [WIDTH_E-1:0] push_data;
   logic [WIDTH_E-1:0] head_data;

   always_comb begin
      grant_l1 = bus.L1_valid & (~bus.L0_valid | (last_grant_q == SRC_L0));
      grant_l0 = bus.L0_valid & ~grant_l1;
   end

   // Readies are held low during reset independently of the FIFO state.
   assign bus.L0_ready = rst_n & ~full & grant_l0;
   assign bus.L1_ready = rst_n & ~full & grant_l1;
   assign push         = bus.L0_ready | bus.L1_ready;
   assign win_data     = grant_l1 ? bus.L1_data : bus.L0_data;

`ifdef MERGE_TAG_EN
   assign push_data = {grant_l1, win_data};
`else
   assign push_data = win_data;
`endif

   always_comb begin
      last_grant_d = last_grant_q;
      if (push) last_grant_d = grant_l1 ? SRC_L1 : SRC_L0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_grant_q <= SRC_L1;
      else        last_grant_q <= last_grant_d;
   end

   merge_fifo #(
      .WIDTH_E (WIDTH_E),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (bus.R_ready),
      .pop_data_o  (head_data),
      .full_o      (full),
      .empty_o     (empty)
   );

   assign bus.R_valid = ~empty;
   assign bus.R_data  = head_data;

endmodule

// File: tb/tb_merge_arb.sv
// Bench for merge_arb: directed scenarios plus a random stall run against a queue-based model.
module tb_merge_arb;
   import merge_pkg::*;

   localparam int WIDTH  = 4;
   localparam int DEPTH  = 2;
   localparam int RW     = WIDTH + TAG_W;
   localparam int N_PKT  = 3000;
   localparam int BUDGET = 40000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   merge_arb_if #(.WIDTH(WIDTH)) bus ();

   merge_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: buffered packets in acceptance order and the id of the last winner.
   logic [RW-1:0] mq[$];
   logic          m_last;
   logic          m_r0, m_r1, m_rv;
   logic [RW-1:0] m_rd;

   function automatic logic [RW-1:0] pk(input logic src, input logic [WIDTH-1:0] d);
      return RW'({src, d});
   endfunction

   task automatic model_eval();
      logic room, win;
      room = (mq.size() < DEPTH);
      if (bus.L0_valid && bus.L1_valid) win = ~m_last;
      else                              win = bus.L1_valid;
      m_r0 = rst_n && room && bus.L0_valid && (win == 1'b0);
      m_r1 = rst_n && room && bus.L1_valid && (win == 1'b1);
      m_rv = rst_n && (mq.size() != 0);
      m_rd = m_rv ? mq[0] : '0;
   endtask

   task automatic drive(input logic v0, input logic [WIDTH-1:0] d0,
                        input logic v1, input logic [WIDTH-1:0] d1, input logic rr);
      bus.L0_valid = v0;
      bus.L0_data  = d0;
      bus.L1_valid = v1;
      bus.L1_data  = d1;
      bus.R_ready  = rr;
      #1;
      model_eval();
   endtask

   task automatic tick(output logic a0, output logic a1);
      logic          pop;
      logic [RW-1:0] e;
      a0  = m_r0;
      a1  = m_r1;
      pop = m_rv && bus.R_ready;
      e   = a0 ? pk(1'b0, bus.L0_data) : pk(1'b1, bus.L1_data);
      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (a0 || a1) begin
         mq.push_back(e);
         m_last = a1;
      end
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      rst_n = 1'b0;
      mq.delete();
      m_last = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic a0, a1;
      rst_n = 1'b0;
      mq.delete();
      m_last = 1'b1;
      drive(1'b1, 4'h3, 1'b1, 4'h5, 1'b1);
      n_total++; if (bus.L0_ready !== 1'b0) $display("FAIL reset_l0_ready got %b want 0", bus.L0_ready); else n_pass++;
      n_total++; if (bus.L1_ready !== 1'b0) $display("FAIL reset_l1_ready got %b want 0", bus.L1_ready); else n_pass++;
      n_total++; if (bus.R_valid !== 1'b0) $display("FAIL reset_r_valid got %b want 0", bus.R_valid); else n_pass++;
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      n_total++; if (bus.R_valid !== 1'b0) $display("FAIL post_reset_r_valid got %b want 0", bus.R_valid); else n_pass++;
      tick(a0, a1);
   endtask

   task automatic test_single();
      logic a0, a1;
      drive(1'b1, 4'h3, 1'b0, '0, 1'b1);
      n_total++; if (bus.L0_ready !== 1'b1) $display("FAIL single_l0_ready got %b want 1", bus.L0_ready); else n_pass++;
      tick(a0, a1);
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      n_total++; if (bus.R_valid !== 1'b1) $display("FAIL single_r_valid got %b want 1", bus.R_valid); else n_pass++;
      n_total++; if (bus.R_data !== pk(1'b0, 4'h3)) $display("FAIL single_r_data got %h want %h", bus.R_data, pk(1'b0, 4'h3)); else n_pass++;
      tick(a0, a1);
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      n_total++; if (bus.R_valid !== 1'b0) $display("FAIL single_drained got %b want 0", bus.R_valid); else n_pass++;
   endtask

   task automatic test_alternate();
      logic          a0, a1;
      logic [RW-1:0] want;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 4'hA, 1'b1, 4'h5, 1'b1);
         n_total++; if (bus.L0_ready !== ((k % 2) == 0)) $display("FAIL alt_l0_ready k=%0d got %b", k, bus.L0_ready); else n_pass++;
         n_total++; if (bus.L1_ready !== ((k % 2) == 1)) $display("FAIL alt_l1_ready k=%0d got %b", k, bus.L1_ready); else n_pass++;
         if (k > 0) begin
            want = ((k % 2) == 1) ? pk(1'b0, 4'hA) : pk(1'b1, 4'h5);
            n_total++; if (bus.R_valid !== 1'b1 || bus.R_data !== want) $display("FAIL alt_r_data k=%0d got %b/%h want 1/%h", k, bus.R_valid, bus.R_data, want); else n_pass++;
         end
         tick(a0, a1);
      end
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      n_total++; if (bus.R_data !== pk(1'b1, 4'h5)) $display("FAIL alt_last got %h want %h", bus.R_data, pk(1'b1, 4'h5)); else n_pass++;
      tick(a0, a1);
   endtask

   task automatic test_backpressure();
      logic a0, a1;
      do_reset();
      drive(1'b1, 4'h1, 1'b0, '0, 1'b0);
      n_total++; if (bus.L0_ready !== 1'b1) $display("FAIL bp_accept1 got %b want 1", bus.L0_ready); else n_pass++;
      tick(a0, a1);
      drive(1'b1, 4'h2, 1'b0, '0, 1'b0);
      n_total++; if (bus.L0_ready !== 1'b1) $display("FAIL bp_accept2 got %b want 1", bus.L0_ready); else n_pass++;
      tick(a0, a1);
      drive(1'b1, 4'h3, 1'b0, '0, 1'b0);
      n_total++; if (bus.L0_ready !== 1'b0) $display("FAIL bp_full_ready got %b want 0", bus.L0_ready); else n_pass++;
      tick(a0, a1);
      drive(1'b1, 4'h3, 1'b0, '0, 1'b1);
      n_total++; if (bus.L0_ready !== 1'b0) $display("FAIL bp_no_pushthrough got %b want 0", bus.L0_ready); else n_pass++;
      n_total++; if (bus.R_data !== pk(1'b0, 4'h1)) $display("FAIL bp_head1 got %h want %h", bus.R_data, pk(1'b0, 4'h1)); else n_pass++;
      tick(a0, a1);
      drive(1'b1, 4'h3, 1'b0, '0, 1'b1);
      n_total++; if (bus.L0_ready !== 1'b1) $display("FAIL bp_accept3 got %b want 1", bus.L0_ready); else n_pass++;
      n_total++; if (bus.R_data !== pk(1'b0, 4'h2)) $display("FAIL bp_head2 got %h want %h", bus.R_data, pk(1'b0, 4'h2)); else n_pass++;
      tick(a0, a1);
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      n_total++; if (bus.R_valid !== 1'b1 || bus.R_data !== pk(1'b0, 4'h3)) $display("FAIL bp_head3 got %b/%h want 1/%h", bus.R_valid, bus.R_data, pk(1'b0, 4'h3)); else n_pass++;
      tick(a0, a1);
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      n_total++; if (bus.R_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", bus.R_valid); else n_pass++;
   endtask

   task automatic test_full_pop();
      logic a0, a1;
      do_reset();
      drive(1'b1, 4'h7, 1'b0, '0, 1'b0);
      tick(a0, a1);
      drive(1'b1, 4'h8, 1'b0, '0, 1'b0);
      tick(a0, a1);
      drive(1'b0, '0, 1'b1, 4'h9, 1'b1);
      n_total++; if (bus.L1_ready !== 1'b0) $display("FAIL fp_pop_only got %b want 0", bus.L1_ready); else n_pass++;
      n_total++; if (bus.R_data !== pk(1'b0, 4'h7)) $display("FAIL fp_head7 got %h want %h", bus.R_data, pk(1'b0, 4'h7)); else n_pass++;
      tick(a0, a1);
      drive(1'b0, '0, 1'b1, 4'h9, 1'b0);
      n_total++; if (bus.L1_ready !== 1'b1) $display("FAIL fp_l1_next got %b want 1", bus.L1_ready); else n_pass++;
      tick(a0, a1);
      drive(1'b0, '0, 1'b1, 4'h4, 1'b0);
      n_total++; if (bus.L1_ready !== 1'b0) $display("FAIL fp_full_again got %b want 0", bus.L1_ready); else n_pass++;
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      n_total++; if (bus.R_data !== pk(1'b0, 4'h8)) $display("FAIL fp_head8 got %h want %h", bus.R_data, pk(1'b0, 4'h8)); else n_pass++;
      tick(a0, a1);
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      n_total++; if (bus.R_data !== pk(1'b1, 4'h9)) $display("FAIL fp_head9 got %h want %h", bus.R_data, pk(1'b1, 4'h9)); else n_pass++;
      tick(a0, a1);
   endtask

   task automatic test_async_reset();
      logic a0, a1;
      do_reset();
      drive(1'b1, 4'h1, 1'b0, '0, 1'b0);
      tick(a0, a1);
      drive(1'b0, '0, 1'b1, 4'h2, 1'b0);
      tick(a0, a1);
      drive(1'b1, 4'h5, 1'b1, 4'h6, 1'b1);
      n_total++; if (bus.R_valid !== 1'b1) $display("FAIL ar_prefill got %b want 1", bus.R_valid); else n_pass++;
      #2;
      rst_n = 1'b0;
      mq.delete();
      m_last = 1'b1;
      #1;
      n_total++; if (bus.R_valid !== 1'b0) $display("FAIL ar_r_valid got %b want 0", bus.R_valid); else n_pass++;
      n_total++; if (bus.L0_ready !== 1'b0 || bus.L1_ready !== 1'b0) $display("FAIL ar_readies got %b%b want 00", bus.L0_ready, bus.L1_ready); else n_pass++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b1, 4'h5, 1'b1, 4'h6, 1'b0);
      n_total++; if (bus.L0_ready !== 1'b1 || bus.L1_ready !== 1'b0) $display("FAIL ar_first_tie got %b%b want 10", bus.L0_ready, bus.L1_ready); else n_pass++;
      tick(a0, a1);
      drive(1'b0, '0, 1'b1, 4'h6, 1'b1);
      n_total++; if (bus.R_data !== pk(1'b0, 4'h5)) $display("FAIL ar_head got %h want %h", bus.R_data, pk(1'b0, 4'h5)); else n_pass++;
      tick(a0, a1);
   endtask

   task automatic test_random();
      logic             a0, a1, p0v, p1v, rr;
      logic [WIDTH-1:0] p0d, p1d;
      int               sent0, sent1, cyc, w0, w1, max0, max1, bad;
      do_reset();
      p0v = 1'b0; p1v = 1'b0; p0d = '0; p1d = '0;
      sent0 = 0; sent1 = 0; cyc = 0; w0 = 0; w1 = 0; max0 = 0; max1 = 0; bad = 0;
      while ((sent0 < N_PKT || sent1 < N_PKT) && cyc < BUDGET) begin
         if (!p0v && sent0 < N_PKT && $urandom_range(0, 9) < 7) begin p0v = 1'b1; p0d = WIDTH'($urandom); end
         if (!p1v && sent1 < N_PKT && $urandom_range(0, 9) < 7) begin p1v = 1'b1; p1d = WIDTH'($urandom); end
         rr = ($urandom_range(0, 9) < 6);
         drive(p0v, p0d, p1v, p1d, rr);
         n_total++;
         if (bus.L0_ready !== m_r0 || bus.L1_ready !== m_r1 || bus.R_valid !== m_rv ||
             (m_rv && bus.R_data !== m_rd)) begin
            if (bad < 10) $display("FAIL rnd_cycle %0d got rdy=%b%b rv=%b rd=%h want rdy=%b%b rv=%b rd=%h",
                                   cyc, bus.L0_ready, bus.L1_ready, bus.R_valid, bus.R_data, m_r0, m_r1, m_rv, m_rd);
            bad++;
         end else n_pass++;
         tick(a0, a1);
         if (p0v && !a0 && a1) w0++;
         if (p1v && !a1 && a0) w1++;
         if (w0 > max0) max0 = w0;
         if (w1 > max1) max1 = w1;
         if (a0) begin p0v = 1'b0; sent0++; w0 = 0; end
         if (a1) begin p1v = 1'b0; sent1++; w1 = 0; end
         cyc++;
      end
      n_total++; if (cyc >= BUDGET) $display("FAIL rnd_budget sent %0d/%0d want %0d each", sent0, sent1, N_PKT); else n_pass++;
      n_total++; if (max0 > 1) $display("FAIL rnd_starve_l0 got %0d want <=1", max0); else n_pass++;
      n_total++; if (max1 > 1) $display("FAIL rnd_starve_l1 got %0d want <=1", max1); else n_pass++;
      for (int k = 0; k <= DEPTH; k++) begin
         drive(1'b0, '0, 1'b0, '0, 1'b1);
         n_total++;
         if (bus.R_valid !== m_rv || (m_rv && bus.R_data !== m_rd))
            $display("FAIL rnd_drain k=%0d got %b/%h want %b/%h", k, bus.R_valid, bus.R_data, m_rv, m_rd);
         else n_pass++;
         tick(a0, a1);
      end
   endtask

   initial begin
      bus.L0_valid = 1'b0; bus.L0_data = '0;
      bus.L1_valid = 1'b0; bus.L1_data = '0;
      bus.R_ready  = 1'b0;
      rst_n = 1'b0;
      m_last = 1'b1;
      test_reset();
      test_single();
      test_alternate();
      test_backpressure();
      test_full_pop();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
